// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned WMASK_W    = DATA_W_DEF / 8;

  typedef enum logic {OWN_I, OWN_D} owner_e;

  typedef enum logic {ST_IDLE, ST_RESP} arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker. Fixed D-over-I priority, or alternating on conflict when
// MEM_ARB_RR_EN is defined (then last_gnt is present).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
`ifdef MEM_ARB_RR_EN
  input  owner_e last_gnt,
`endif
  output logic   gnt_i,
  output logic   gnt_d
);

`ifdef MEM_ARB_RR_EN
  // On conflict the port that did not win last time goes first.
  assign gnt_d = req_d & (~req_i | (last_gnt == OWN_I));
`else
  assign gnt_d = req_d;
`endif
  assign gnt_i = req_i & ~gnt_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port BRAM between instruction fetch (I) and load/store (D).
// Optional round-robin arbitration enabled by defining MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MEM_WORDS = 150001
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_ren,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [ADDR_W-1:0] MemWordsA = ADDR_W'(MEM_WORDS);

  logic       w_pick_i, w_pick_d;
  logic       w_i_oor, w_d_oor, w_d_store;
  arb_state_e r_state, w_state_nxt;
  owner_e     r_own, w_own_nxt;
  logic       r_oor, w_oor_nxt;

  assign w_i_oor   = (i_addr >> 2) >= MemWordsA;
  assign w_d_oor   = (d_addr >> 2) >= MemWordsA;
  assign w_d_store = |d_wmask;

`ifdef MEM_ARB_RR_EN
  owner_e r_last_gnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_gnt <= OWN_I;
    end else if (d_gnt) begin
      r_last_gnt <= OWN_D;
    end else if (i_gnt) begin
      r_last_gnt <= OWN_I;
    end
  end

  mem_arb_pick u_pick (
    .req_i    (i_req),
    .req_d    (d_req),
    .last_gnt (r_last_gnt),
    .gnt_i    (w_pick_i),
    .gnt_d    (w_pick_d)
  );
`else
  mem_arb_pick u_pick (
    .req_i (i_req),
    .req_d (d_req),
    .gnt_i (w_pick_i),
    .gnt_d (w_pick_d)
  );
`endif

  // Nothing is granted while in reset so the memory cannot be written then.
  assign i_gnt = w_pick_i & resetn;
  assign d_gnt = w_pick_d & resetn;

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_own_nxt   = r_own;
    w_oor_nxt   = 1'b0;
    mem_addr    = '0;
    mem_ren     = 1'b0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    d_err       = 1'b0;
    if (d_gnt) begin
      mem_addr = d_addr;
      d_err    = w_d_oor;
      if (w_d_store) begin
        mem_wdata = d_wdata;
        mem_wmask = w_d_oor ? '0 : d_wmask;
      end else begin
        mem_ren     = 1'b1;
        w_state_nxt = ST_RESP;
        w_own_nxt   = OWN_D;
        w_oor_nxt   = w_d_oor;
      end
    end else if (i_gnt) begin
      mem_addr    = {i_addr[ADDR_W-1:2], 2'b00};
      mem_ren     = 1'b1;
      w_state_nxt = ST_RESP;
      w_own_nxt   = OWN_I;
      w_oor_nxt   = w_i_oor;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_own   <= OWN_I;
      r_oor   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_own   <= w_own_nxt;
      r_oor   <= w_oor_nxt;
    end
  end

  // Out-of-range reads return zero instead of whatever the memory drives.
  assign i_rvalid = (r_state == ST_RESP) && (r_own == OWN_I);
  assign d_rvalid = (r_state == ST_RESP) && (r_own == OWN_D);
  assign i_rdata  = r_oor ? '0 : mem_rdata;
  assign d_rdata  = r_oor ? '0 : mem_rdata;

`ifndef SYNTHESIS
  a_i_hold: assert property (@(posedge clk) disable iff (!resetn)
                             (i_req && !i_gnt) |=> i_req);
  a_d_hold: assert property (@(posedge clk) disable iff (!resetn)
                             (d_req && !d_gnt) |=> d_req);
  a_onehot: assert property (@(posedge clk) disable iff (!resetn) !(i_gnt && d_gnt));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a small behavioural BRAM.
module tb_mem_port_arbiter;

  localparam int unsigned MEM_WORDS = 150001;
  localparam logic [31:0] OOR       = 32'(4 * MEM_WORDS);

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, mem_ren;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_wmask   (d_wmask),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_ren   (mem_ren),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata)
  );

  // 64-word BRAM model; word k initialised to 0xA000_0000 + k, index wraps.
  logic [31:0] mem [64];
  initial for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 + 32'(k);

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic [3:0]  dm;
    logic [31:0] dd;
    logic        eig;
    logic        edg;
    logic [31:0] ea;
    logic        eren;
    logic [3:0]  ewm;
    logic        eerr;
    logic        eirv;
    logic        edrv;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic ir, input logic [31:0] ia, input logic dr,
                     input logic [31:0] da, input logic [3:0] dm, input logic [31:0] dd,
                     input logic eig, input logic edg, input logic [31:0] ea, input logic eren,
                     input logic [3:0] ewm, input logic eerr, input logic eirv,
                     input logic edrv, input logic [31:0] erd);
    vec_t v;
    v = '{name, ir, ia, dr, da, dm, dd, eig, edg, ea, eren, ewm, eerr, eirv, edrv, erd};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [3:0] dm, input logic [31:0] dd);
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wmask = dm; d_wdata = dd;
  endtask

  logic exp_d [4];

  initial begin
    // name      ir ia     dr da     dm    dd            eig edg ea  ren wm  err irv drv rdata
    add("idle0",  0, 0,     0, 0,     4'h0, 0,            0, 0, 0,    0, 4'h0, 0, 0, 0, 0);
    add("i0",     1, 0,     0, 0,     4'h0, 0,            1, 0, 0,    1, 4'h0, 0, 0, 0, 0);
    add("i4",     1, 4,     0, 0,     4'h0, 0,            1, 0, 4,    1, 4'h0, 0, 1, 0, 32'hA000_0000);
    add("i8",     1, 8,     0, 0,     4'h0, 0,            1, 0, 8,    1, 4'h0, 0, 1, 0, 32'hA000_0001);
    add("idle1",  0, 0,     0, 0,     4'h0, 0,            0, 0, 0,    0, 4'h0, 0, 1, 0, 32'hA000_0002);
    add("st10",   0, 0,     1, 32'h10, 4'h3, 32'hDEADBEEF, 0, 1, 32'h10, 0, 4'h3, 0, 0, 0, 0);
    add("ld10",   0, 0,     1, 32'h10, 4'h0, 0,           0, 1, 32'h10, 1, 4'h0, 0, 0, 0, 0);
    add("idle2",  0, 0,     0, 0,     4'h0, 0,            0, 0, 0,    0, 4'h0, 0, 0, 1, 32'hA000_BEEF);
    for (int k = 0; k < 10; k++)
      add("gate", 0, 0,     0, 32'h20, 4'hF, 32'hFFFF_FFFF, 0, 0, 0,  0, 4'h0, 0, 0, 0, 0);
    add("oor_st", 0, 0,     1, OOR,   4'hF, 32'h12345678, 0, 1, OOR,  0, 4'h0, 1, 0, 0, 0);
    add("ld0",    0, 0,     1, 0,     4'h0, 0,            0, 1, 0,    1, 4'h0, 0, 0, 0, 0);
    add("idle3",  0, 0,     0, 0,     4'h0, 0,            0, 0, 0,    0, 4'h0, 0, 0, 1, 32'hA000_0000);
    add("oor_ld", 0, 0,     1, OOR,   4'h0, 0,            0, 1, OOR,  1, 4'h0, 1, 0, 0, 0);
    add("idle4",  0, 0,     0, 0,     4'h0, 0,            0, 0, 0,    0, 4'h0, 0, 0, 1, 0);
    add("oor_if", 1, OOR,   0, 0,     4'h0, 0,            1, 0, OOR,  1, 4'h0, 0, 0, 0, 0);
    add("idle5",  0, 0,     0, 0,     4'h0, 0,            0, 0, 0,    0, 4'h0, 0, 1, 0, 0);
    add("pipe_i", 1, 32'hE, 0, 0,     4'h0, 0,            1, 0, 32'hC, 1, 4'h0, 0, 0, 0, 0);
    add("pipe_d", 0, 0,     1, 32'h14, 4'h0, 0,           0, 1, 32'h14, 1, 4'h0, 0, 1, 0, 32'hA000_0003);
    add("idle6",  0, 0,     0, 0,     4'h0, 0,            0, 0, 0,    0, 4'h0, 0, 0, 1, 32'hA000_0005);

`ifdef MEM_ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset: outputs quiet even with requests asserted.
    resetn = 1'b0;
    drive(1, 32'h4, 1, 32'h8, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    chk("rst/i_gnt", 32'(i_gnt), 0);
    chk("rst/d_gnt", 32'(d_gnt), 0);
    chk("rst/i_rvalid", 32'(i_rvalid), 0);
    chk("rst/d_rvalid", 32'(d_rvalid), 0);
    chk("rst/d_err", 32'(d_err), 0);
    chk("rst/mem_ren", 32'(mem_ren), 0);
    chk("rst/mem_wmask", 32'(mem_wmask), 0);
    chk("rst/mem_addr", mem_addr, 0);
    chk("rst/mem_wdata", mem_wdata, 0);
    drive(0, 0, 0, 0, 4'h0, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    foreach (vecs[n]) begin
      drive(vecs[n].ir, vecs[n].ia, vecs[n].dr, vecs[n].da, vecs[n].dm, vecs[n].dd);
      @(negedge clk);
      chk({vecs[n].name, "/i_gnt"}, 32'(i_gnt), 32'(vecs[n].eig));
      chk({vecs[n].name, "/d_gnt"}, 32'(d_gnt), 32'(vecs[n].edg));
      chk({vecs[n].name, "/mem_ren"}, 32'(mem_ren), 32'(vecs[n].eren));
      chk({vecs[n].name, "/mem_wmask"}, 32'(mem_wmask), 32'(vecs[n].ewm));
      chk({vecs[n].name, "/d_err"}, 32'(d_err), 32'(vecs[n].eerr));
      chk({vecs[n].name, "/i_rvalid"}, 32'(i_rvalid), 32'(vecs[n].eirv));
      chk({vecs[n].name, "/d_rvalid"}, 32'(d_rvalid), 32'(vecs[n].edrv));
      if (vecs[n].eig || vecs[n].edg) chk({vecs[n].name, "/mem_addr"}, mem_addr, vecs[n].ea);
      if (vecs[n].ewm != 0) chk({vecs[n].name, "/mem_wdata"}, mem_wdata, vecs[n].dd);
      if (vecs[n].eirv) chk({vecs[n].name, "/i_rdata"}, i_rdata, vecs[n].erd);
      if (vecs[n].edrv) chk({vecs[n].name, "/d_rdata"}, d_rdata, vecs[n].erd);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 4'h0, 0);
    chk("gate/mem8", mem[8], 32'hA000_0008);
    chk("oor_st/mem49", mem[49], 32'hA000_0031);

    // Reset in the response cycle of a load.
    drive(0, 0, 1, 32'h8, 4'h0, 0);
    @(negedge clk);
    chk("rstmid/d_gnt", 32'(d_gnt), 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 0);
    @(negedge clk);
    chk("rstmid/d_rvalid_in", 32'(d_rvalid), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rstmid/d_rvalid_after", 32'(d_rvalid), 0);
    chk("rstmid/i_rvalid_after", 32'(i_rvalid), 0);
    @(posedge clk); #1;
    drive(1, 32'h4, 0, 0, 4'h0, 0);
    @(negedge clk);
    chk("rstmid/i_gnt", 32'(i_gnt), 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 4'h0, 0);
    @(negedge clk);
    chk("rstmid/i_rvalid", 32'(i_rvalid), 1);
    chk("rstmid/i_rdata", i_rdata, 32'hA000_0001);
    @(posedge clk); #1;

    // Conflict: fetch and store both held for four cycles.
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h18, 1, 32'h3C, 4'hF, 32'h55AA_55AA);
      @(negedge clk);
      chk($sformatf("conf%0d/d_gnt", k), 32'(d_gnt), 32'(exp_d[k]));
      chk($sformatf("conf%0d/i_gnt", k), 32'(i_gnt), 32'(!exp_d[k]));
      chk($sformatf("conf%0d/mem_wmask", k), 32'(mem_wmask), exp_d[k] ? 32'hF : 32'h0);
      chk($sformatf("conf%0d/mem_ren", k), 32'(mem_ren), exp_d[k] ? 32'h0 : 32'h1);
      chk($sformatf("conf%0d/d_rvalid", k), 32'(d_rvalid), 0);
      if (k > 0) chk($sformatf("conf%0d/i_rvalid", k), 32'(i_rvalid), 32'(!exp_d[k-1]));
      @(posedge clk); #1;
    end
`ifndef MEM_ARB_RR_EN
    drive(1, 32'h18, 0, 0, 4'h0, 0);
    @(negedge clk);
    chk("conf_tail/i_gnt", 32'(i_gnt), 1);
    chk("conf_tail/mem_wmask", 32'(mem_wmask), 0);
    chk("conf_tail/i_rvalid", 32'(i_rvalid), 0);
    @(posedge clk); #1;
`endif
    drive(0, 0, 0, 0, 4'h0, 0);
    @(negedge clk);
    chk("conf_end/i_rvalid", 32'(i_rvalid), 1);
    chk("conf_end/i_rdata", i_rdata, 32'hA000_0006);
    chk("conf_end/d_rvalid", 32'(d_rvalid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
